// File: rtl/fetch_unit_pkg.sv
// Shared types, bus widths and helpers for the instruction fetch stage.
// Bus widths and the fetch step also serve as the common macro set for neighbouring stages.
package fetch_unit_pkg;

    localparam int   INST_ADDR_BUS = 32;
    localparam int   INST_DATA_BUS = 32;
    localparam logic ENABLE        = 1'b1;
    localparam logic DISABLE       = 1'b0;

    typedef logic [INST_ADDR_BUS-1:0] inst_addr_t;
    typedef logic [INST_DATA_BUS-1:0] inst_data_t;

    localparam inst_addr_t INST_FETCH_STEP = 32'd4;

    // One queue entry: the fetched word tagged with the address it came from.
    typedef struct packed {
        inst_addr_t pc;
        inst_data_t instr;
    } fetch_pair_t;

    function automatic inst_addr_t word_align(inst_addr_t addr);
        return addr & ~inst_addr_t'(3);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Memory request/response, redirect and decode handshake signals of the fetch stage.
// The master modport is the fetch unit; the slave modport is its environment.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic       mem_request_enable;
    logic       mem_request_ready;
    inst_addr_t mem_request_addr;
    logic       mem_response_valid;
    inst_data_t mem_response_data;
    logic       redirect_enable;
    inst_addr_t redirect_addr;
    logic       id_valid;
    logic       id_ready;
    inst_addr_t program_counter;
    inst_data_t instruction;

    modport master (
        output mem_request_enable, mem_request_addr, id_valid, program_counter, instruction,
        input  mem_request_ready, mem_response_valid, mem_response_data,
               redirect_enable, redirect_addr, id_ready
    );

    modport slave (
        input  mem_request_enable, mem_request_addr, id_valid, program_counter, instruction,
        output mem_request_ready, mem_response_valid, mem_response_data,
               redirect_enable, redirect_addr, id_ready
    );

endinterface

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of {pc, instruction} pairs; clear wins over push and pop.
// Overflow is prevented upstream by the fetch credit rule, so no full flag is needed.
module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter int         DEPTH    = 2,
    parameter inst_addr_t RESET_PC = '0,
    localparam int        PTR_W    = $clog2(DEPTH),
    localparam int        CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             clear_i,
    input  fetch_pair_t      data_i,
    output fetch_pair_t      head_o,
    output logic [CNT_W-1:0] count_o
);

    fetch_pair_t      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no path leaves it unassigned and no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: storage is reset (it is only a few flops) so the head shows RESET_PC and a zero word out of reset.
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= {RESET_PC, INST_DATA_BUS'(0)};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples pre-edge values regardless of statement order.
            if (push_i && !clear_i) mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: program counter, request credits and redirect flushing.
// Words are buffered with their addresses in fetch_queue and handed to decode in order.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int         DEPTH    = 2,
    parameter inst_addr_t RESET_PC = 32'h0000_0000
) (
    input  logic          clock,
    input  logic          reset,
    fetch_unit_if.master  bus
);

    localparam int               CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0]   CREDITS = (CNT_W + 1)'(DEPTH);

    inst_addr_t       fetch_pc_q, fetch_pc_d;
    inst_addr_t       resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] discard_q, discard_d;
    logic [CNT_W-1:0] count;
    logic [CNT_W:0]   credit_used;
    logic             req_fire, resp_live, push, pop;
    fetch_pair_t      push_pair, head;

    // Buffered plus in-flight words may never exceed the queue depth.
    assign credit_used = {1'b0, count} + {1'b0, outstanding_q};
    assign bus.mem_request_enable = (!reset && !bus.redirect_enable && (credit_used < CREDITS))
                                    ? ENABLE : DISABLE;
    assign bus.mem_request_addr   = fetch_pc_q;

    assign req_fire  = bus.mem_request_enable && bus.mem_request_ready;
    assign resp_live = bus.mem_response_valid && (discard_q == '0);
    assign push      = resp_live && !bus.redirect_enable;
    assign pop       = bus.id_valid && bus.id_ready;
    assign push_pair = {resp_pc_q, bus.mem_response_data};

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        if (bus.redirect_enable) begin
            // A response landing this cycle retires one in-flight fetch, stale or live.
            fetch_pc_d    = word_align(bus.redirect_addr);
            resp_pc_d     = word_align(bus.redirect_addr);
            discard_d     = discard_q + outstanding_q - CNT_W'(bus.mem_response_valid);
            outstanding_d = '0;
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + INST_FETCH_STEP;
            if (bus.mem_response_valid && (discard_q != '0)) discard_d = discard_q - CNT_W'(1);
            if (resp_live) resp_pc_d = resp_pc_q + INST_FETCH_STEP;
            outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(resp_live);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) u_queue (
        .clk     (clock),
        .rst     (reset),
        .push_i  (push),
        .pop_i   (pop),
        .clear_i (bus.redirect_enable),
        .data_i  (push_pair),
        .head_o  (head),
        .count_o (count)
    );

    assign bus.id_valid        = (count != '0);
    assign bus.program_counter = head.pc;
    assign bus.instruction     = head.instr;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// against an in-order PC reference model and an arbitrary-latency memory.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int         DEPTH   = 4;
    localparam inst_addr_t WRAP_PC = 32'hFFFF_FFF8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    fetch_unit_if bus();
    fetch_unit_if bus2();

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    fetch_unit #(.DEPTH(2), .RESET_PC(WRAP_PC)) dut2 (
        .clock (clock),
        .reset (reset),
        .bus   (bus2)
    );

    typedef struct {
        inst_addr_t addr;
        int         due;
    } pend_t;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;
    pend_t      pend[$];
    pend_t      pend2[$];
    inst_addr_t pop2_pc[$];
    inst_data_t pop2_instr[$];

    // Stimulus knobs applied by cycle()
    logic       k_ready = 1'b1, k_id_ready = 1'b1, k_redirect = 1'b0, k_rand_resp = 1'b0;
    inst_addr_t k_redirect_addr = '0;
    int         k_lat = 1;

    // Reference model: next expected request address and next expected decoded pc
    inst_addr_t exp_fetch_pc, exp_pop_pc;
    int         n_acc, n_pop;

    // Last observed cycle
    logic       p_valid, p_id_ready, p_redirect, p_en, p_ready, p_resp;
    inst_addr_t p_pc, p_addr;
    inst_data_t p_instr;

    function automatic inst_data_t mem_word(inst_addr_t a);
        return (a ^ 32'h5A5A_C3C3) * 32'h9E37_79B1;
    endfunction

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s (cycle %0d): got %h, expected %h", tag, cyc, got, exp);
    endtask

    task automatic drive_idle();
        bus.mem_request_ready  = 1'b0;
        bus.mem_response_valid = 1'b0;
        bus.mem_response_data  = '0;
        bus.redirect_enable    = 1'b0;
        bus.redirect_addr      = '0;
        bus.id_ready           = 1'b0;
        bus2.mem_request_ready  = 1'b0;
        bus2.mem_response_valid = 1'b0;
        bus2.mem_response_data  = '0;
        bus2.redirect_enable    = 1'b0;
        bus2.redirect_addr      = '0;
        bus2.id_ready           = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        drive_idle();
        pend.delete();
        pend2.delete();
        pop2_pc.delete();
        pop2_instr.delete();
        repeat (2) @(negedge clock);
        #1;
        check("rst_req_en",   bus.mem_request_enable, 1'b0);
        check("rst_req_addr", bus.mem_request_addr, 32'h0000_0000);
        check("rst_id_valid", bus.id_valid, 1'b0);
        check("rst_pc",       bus.program_counter, 32'h0000_0000);
        check("rst_instr",    bus.instruction, 32'h0);
        check("rst2_pc",      bus2.program_counter, WRAP_PC);
        check("rst2_addr",    bus2.mem_request_addr, WRAP_PC);
        @(negedge clock);
        reset        = 1'b0;
        exp_fetch_pc = 32'h0000_0000;
        exp_pop_pc   = 32'h0000_0000;
        cyc = 0;  n_acc = 0;  n_pop = 0;
        p_valid = 0; p_id_ready = 0; p_redirect = 0; p_en = 0; p_ready = 0; p_resp = 0;
        p_pc = '0; p_addr = '0; p_instr = '0;
        k_ready = 1'b1; k_id_ready = 1'b1; k_redirect = 1'b0; k_rand_resp = 1'b0; k_lat = 1;
    endtask

    // One clock: drive at the falling edge, observe 1 ns later, then wait for the next falling edge.
    task automatic cycle();
        logic acc, pop;
        pend_t e;
        bus.mem_response_valid = 1'b0;
        bus.mem_response_data  = $urandom;
        if (pend.size() != 0 && pend[0].due <= cyc && (!k_rand_resp || $urandom_range(3) != 0)) begin
            bus.mem_response_valid = 1'b1;
            bus.mem_response_data  = mem_word(pend[0].addr);
            void'(pend.pop_front());
        end
        bus.mem_request_ready = k_ready;
        bus.id_ready          = k_id_ready;
        bus.redirect_enable   = k_redirect;
        bus.redirect_addr     = k_redirect_addr;

        bus2.mem_response_valid = 1'b0;
        bus2.mem_response_data  = '0;
        if (pend2.size() != 0 && pend2[0].due <= cyc) begin
            bus2.mem_response_valid = 1'b1;
            bus2.mem_response_data  = mem_word(pend2[0].addr);
            void'(pend2.pop_front());
        end
        bus2.mem_request_ready = 1'b1;
        bus2.id_ready          = 1'b1;
        #1;

        acc = bus.mem_request_enable && bus.mem_request_ready;
        pop = bus.id_valid && bus.id_ready && !bus.redirect_enable;

        if (bus.mem_response_valid)
            check("resp_expected", (dut.outstanding_q != '0) || (dut.discard_q != '0), 1'b1);
        if (k_redirect) check("req_in_redirect", bus.mem_request_enable, 1'b0);
        if (p_redirect) check("valid_after_redirect", bus.id_valid, 1'b0);
        if (p_en && !p_ready && !k_redirect) begin
            check("req_hold_en",   bus.mem_request_enable, 1'b1);
            check("req_hold_addr", bus.mem_request_addr, p_addr);
        end
        if (p_valid && !p_id_ready && !p_redirect) begin
            check("id_hold_valid", bus.id_valid, 1'b1);
            check("id_hold_pc",    bus.program_counter, p_pc);
            check("id_hold_instr", bus.instruction, p_instr);
        end
        if (acc) begin
            check("req_addr", bus.mem_request_addr, exp_fetch_pc);
            e.addr = bus.mem_request_addr;
            e.due  = cyc + k_lat;
            pend.push_back(e);
            exp_fetch_pc = exp_fetch_pc + 32'd4;
            n_acc++;
        end
        if (pop) begin
            check("pop_pc",    bus.program_counter, exp_pop_pc);
            check("pop_instr", bus.instruction, mem_word(exp_pop_pc));
            exp_pop_pc = exp_pop_pc + 32'd4;
            n_pop++;
        end
        if (k_redirect) begin
            exp_fetch_pc = k_redirect_addr & ~32'h3;
            exp_pop_pc   = k_redirect_addr & ~32'h3;
        end

        if (bus2.id_valid) begin
            pop2_pc.push_back(bus2.program_counter);
            pop2_instr.push_back(bus2.instruction);
        end
        if (bus2.mem_request_enable) begin
            e.addr = bus2.mem_request_addr;
            e.due  = cyc + 1;
            pend2.push_back(e);
        end

        p_valid = bus.id_valid;   p_id_ready = k_id_ready;  p_redirect = k_redirect;
        p_en    = bus.mem_request_enable;  p_ready = k_ready;
        p_resp  = bus.mem_response_valid;
        p_pc    = bus.program_counter;     p_instr = bus.instruction;
        p_addr  = bus.mem_request_addr;
        @(negedge clock);
        cyc++;
    endtask

    initial begin
        bit found;
        int pops_before;
        drive_idle();

        // Streaming at latency 1, decode always ready
        do_reset();
        cycle();
        check("first_req_cycle0", p_en, 1'b1);
        check("valid_cycle0", p_valid, 1'b0);
        cycle();
        check("valid_cycle1", p_valid, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cycle();
            check("stream_valid", p_valid, 1'b1);
        end
        check("stream_pops", n_pop, 8);

        // Wrapping reset address on the second instance
        check("wrap_pop_count", pop2_pc.size() >= 3, 1'b1);
        if (pop2_pc.size() >= 3) begin
            check("wrap_pc0", pop2_pc[0], 32'hFFFF_FFF8);
            check("wrap_pc1", pop2_pc[1], 32'hFFFF_FFFC);
            check("wrap_pc2", pop2_pc[2], 32'h0000_0000);
            check("wrap_instr2", pop2_instr[2], mem_word(32'h0000_0000));
        end

        // Decode stalled: credits stop requests after DEPTH, head pair held
        do_reset();
        k_id_ready = 1'b0;
        repeat (10) cycle();
        check("stall_accepts", n_acc, DEPTH);
        check("stall_req_en", p_en, 1'b0);
        check("stall_head_pc", p_pc, 32'h0000_0000);
        k_id_ready = 1'b1;
        repeat (12) cycle();
        check("drain_progress", n_pop >= DEPTH + 4, 1'b1);

        // Redirect with two late responses in flight
        do_reset();
        k_lat = 3;
        cycle();
        cycle();
        check("two_in_flight", n_acc, 2);
        k_ready = 1'b0;  k_redirect = 1'b1;  k_redirect_addr = 32'h0000_1003;
        cycle();
        k_ready = 1'b1;  k_redirect = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            found = p_valid;
        end
        check("redirect_found_valid", found, 1'b1);
        check("redirect_first_pc", p_pc, 32'h0000_1000);
        check("redirect_first_instr", p_instr, mem_word(32'h0000_1000));

        // Redirect coinciding with a response and a pop
        do_reset();
        repeat (5) cycle();
        k_redirect = 1'b1;  k_redirect_addr = 32'h0000_2002;
        cycle();
        check("coincide_resp_pop", p_resp && p_valid, 1'b1);
        k_redirect = 1'b0;
        cycle();
        check("restart_en", p_en, 1'b1);
        check("restart_addr", p_addr, 32'h0000_2000);
        pops_before = n_pop;
        repeat (6) cycle();
        check("restart_progress", n_pop > pops_before, 1'b1);

        // Randomized traffic against the reference model
        do_reset();
        k_rand_resp = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            k_ready         = ($urandom_range(3) != 0);
            k_id_ready      = ($urandom_range(3) != 0);
            k_lat           = $urandom_range(4, 1);
            k_redirect      = ($urandom_range(49) == 0);
            k_redirect_addr = $urandom;
            cycle();
        end
        check("random_progress", n_pop > 1000, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
